my_adder_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshaking on both sides. It generalises the fixed 16-bit combinational adder: width is configurable, the carry chain is split across `STAGES` registered slices, and the block adds subtract mode, carry-in, carry-out and signed-overflow flags. It sits between an operand producer and a result consumer in the datapath and absorbs consumer backpressure without losing data.

---
 rtl/my_adder_pkg.sv | 35 +++
 rtl/my_adder_slice.sv | 49 ++++
 rtl/my_adder_pipe.sv | 148 ++++++++++++++
 tb/tb_my_adder_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined adder/subtractor.
package my_adder_pkg;

  typedef enum logic {
    ModeAdd = 1'b0,
    ModeSub = 1'b1
  } adder_mode_e;

  // Per-slice control payload; the chunk sum travels beside it on its own bus.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } slice_t;

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Chunks held in a triangular skew/deskew buffer across all stages.
  function automatic int unsigned tri_chunks(input int unsigned stages);
    return (stages * (stages - 1)) / 2;
  endfunction

  // Chunk offset of stage k's operand skew slot (stage k holds chunks k+1..stages-1).
  function automatic int unsigned skew_off(input int unsigned k, input int unsigned stages);
    return (k * (stages - 1)) - ((k * (k - 1)) / 2);
  endfunction

  // Chunk offset of stage k's result deskew slot (stage k holds chunks 0..k-1).
  function automatic int unsigned dsk_off(input int unsigned k);
    return (k * (k - 1)) / 2;
  endfunction

endpackage

// File: rtl/my_adder_slice.sv
// One registered ripple slice of the pipelined adder: adds a chunk plus carry-in and
// holds its result, carry and valid bit while the pipeline is stalled.
module my_adder_slice
  import my_adder_pkg::*;
#(
  parameter int unsigned ChunkW   = 4,
  parameter bit          TopSlice = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [ChunkW-1:0] a_i,
  input  logic [ChunkW-1:0] b_i,
  input  logic              carry_i,
  output logic [ChunkW-1:0] sum_o,
  output slice_t            ctl_o
);

  logic [ChunkW:0]   total;
  logic              carry_msb;
  logic [ChunkW-1:0] sum_d, sum_q;
  slice_t            ctl_d, ctl_q;

  always_comb begin
    total     = {1'b0, a_i} + {1'b0, b_i} + {{ChunkW{1'b0}}, carry_i};
    // Carry into the top bit recovered from the sum bit and its two operand bits.
    carry_msb = total[ChunkW-1] ^ a_i[ChunkW-1] ^ b_i[ChunkW-1];
    sum_d     = total[ChunkW-1:0];
    ctl_d     = '0;
    ctl_d.valid = valid_i;
    ctl_d.carry = total[ChunkW];
    ctl_d.ovf   = TopSlice ? (total[ChunkW] ^ carry_msb) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ctl_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
      ctl_q <= ctl_d;
    end
  end

  assign sum_o = sum_q;
  assign ctl_o = ctl_q;

endmodule

// File: rtl/my_adder_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready on both sides; the carry
// chain is split over STAGES registered slices with operand skew and result deskew.
module my_adder_pipe
  import my_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned ChunkW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : gen_cfg_err
    $error("my_adder_pipe: WIDTH must be a nonzero multiple of STAGES");
  end

  adder_mode_e mode;
  logic        adv;
  logic [WIDTH-1:0] b_eff;
  logic        c0;

  logic [STAGES-1:0][ChunkW-1:0] a_in, b_in, s_chunk;
  logic [STAGES-1:0]             c_in, v_in;
  slice_t [STAGES-1:0]           ctl;

  // Subtract is A + ~B + 1; the mode only matters at capture time.
  always_comb begin
    mode  = sub ? ModeSub : ModeAdd;
    b_eff = (mode == ModeSub) ? ~b : b;
    c0    = (mode == ModeSub) ? 1'b1 : cin;
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  if (STAGES > 1) begin : gen_pipe
    localparam int unsigned TriW    = ChunkW * tri_chunks(STAGES);
    localparam int unsigned LastOff = ChunkW * dsk_off(STAGES - 1);

    logic [TriW-1:0] a_skw_d, a_skw_q, b_skw_d, b_skw_q, dsk_d, dsk_q;

    always_comb begin
      a_in    = '0;
      b_in    = '0;
      c_in    = '0;
      v_in    = '0;
      a_skw_d = '0;
      b_skw_d = '0;
      dsk_d   = '0;
      a_in[0] = a[ChunkW-1:0];
      b_in[0] = b_eff[ChunkW-1:0];
      c_in[0] = c0;
      v_in[0] = in_valid;
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        // Operand skew: stage k keeps chunks k+1.., dropping the one slice k+1 consumes.
        for (int unsigned j = 0; j < STAGES - 1 - k; j++) begin
          if (k == 0) begin
            a_skw_d[j*ChunkW +: ChunkW] = a[(j+1)*ChunkW +: ChunkW];
            b_skw_d[j*ChunkW +: ChunkW] = b_eff[(j+1)*ChunkW +: ChunkW];
          end else begin
            a_skw_d[(skew_off(k, STAGES)+j)*ChunkW +: ChunkW] =
                a_skw_q[(skew_off(k-1, STAGES)+j+1)*ChunkW +: ChunkW];
            b_skw_d[(skew_off(k, STAGES)+j)*ChunkW +: ChunkW] =
                b_skw_q[(skew_off(k-1, STAGES)+j+1)*ChunkW +: ChunkW];
          end
        end
        // Result deskew: stage k+1 carries chunks 0..k alongside its own slice.
        for (int unsigned j = 0; j < k; j++) begin
          dsk_d[(dsk_off(k+1)+j)*ChunkW +: ChunkW] = dsk_q[(dsk_off(k)+j)*ChunkW +: ChunkW];
        end
        dsk_d[(dsk_off(k+1)+k)*ChunkW +: ChunkW] = s_chunk[k];
        a_in[k+1] = a_skw_q[skew_off(k, STAGES)*ChunkW +: ChunkW];
        b_in[k+1] = b_skw_q[skew_off(k, STAGES)*ChunkW +: ChunkW];
        c_in[k+1] = ctl[k].carry;
        v_in[k+1] = ctl[k].valid;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_skw_q <= '0;
        b_skw_q <= '0;
        dsk_q   <= '0;
      end else if (adv) begin
        a_skw_q <= a_skw_d;
        b_skw_q <= b_skw_d;
        dsk_q   <= dsk_d;
      end
    end

    assign sum = {s_chunk[STAGES-1], dsk_q[LastOff +: (STAGES-1)*ChunkW]};
  end else begin : gen_single
    always_comb begin
      a_in    = '0;
      b_in    = '0;
      c_in    = '0;
      v_in    = '0;
      a_in[0] = a;
      b_in[0] = b_eff;
      c_in[0] = c0;
      v_in[0] = in_valid;
    end

    assign sum = s_chunk[0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_slice
    my_adder_slice #(
      .ChunkW  (ChunkW),
      .TopSlice(k == STAGES - 1)
    ) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .valid_i(v_in[k]),
      .a_i    (a_in[k]),
      .b_i    (b_in[k]),
      .carry_i(c_in[k]),
      .sum_o  (s_chunk[k]),
      .ctl_o  (ctl[k])
    );
  end

  // Only the top slice computes overflow; the others tie their flag to 0.
  always_comb begin
    ovf = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ovf = ovf | ctl[k].ovf;
    end
  end

  assign out_valid = ctl[STAGES-1].valid;
  assign cout      = ctl[STAGES-1].carry;

endmodule

// File: tb/tb_my_adder_pipe.sv
// Bench for my_adder_pipe: directed vector table, streaming, backpressure, mid-flight
// reset and randomized traffic scored against an arithmetic reference model.
module tb_my_adder_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[10];
  int   n_cmp, n_bad, n_out;
  logic stall_seen;
  res_t held;

  my_adder_pipe #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    res_t   r;
    longint ua, ub, sa, sb, full, sr, lim;
    ua  = longint'(x);
    ub  = longint'(y);
    sa  = longint'($signed(x));
    sb  = longint'($signed(y));
    lim = longint'(1) << (W - 1);
    if (s) begin
      full   = ua - ub;
      sr     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + longint'(ci);
      sr     = sa + sb + longint'(ci);
      r.cout = (full >= (longint'(1) << W));
    end
    r.sum = full[W-1:0];
    r.ovf = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                               input logic s, input logic [W-1:0] es, input logic ec,
                               input logic eo);
    vec_t v;
    v.a = x; v.b = y; v.cin = ci; v.sub = s;
    v.exp.sum = es; v.exp.cout = ec; v.exp.ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: score transfers at the negedge, then step past the next rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (rst_n) begin
      if (stall_seen) begin
        chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_hold_sum", {16'b0, sum}, {16'b0, held.sum});
        chk("stall_hold_flags", {30'b0, cout, ovf}, {30'b0, held.cout, held.ovf});
      end
      stall_seen = out_valid && !out_ready;
      held.sum = sum; held.cout = cout; held.ovf = ovf;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got result 0x%0h, expected no output", sum);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", {16'b0, sum}, {16'b0, e.sum});
          chk("out_cout", {31'b0, cout}, {31'b0, e.cout});
          chk("out_ovf", {31'b0, ovf}, {31'b0, e.ovf});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  initial begin
    int          lat, n_acc, ir_low, stale;
    logic [15:0] pat, exp_pat;

    n_cmp = 0; n_bad = 0; n_out = 0; stall_seen = 1'b0; held = '0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = mkv(16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[1] = mkv(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[2] = mkv(16'h000F, 16'h000F, 1'b1, 1'b0, 16'h001F, 1'b0, 1'b0);
    vecs[3] = mkv(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    vecs[4] = mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    vecs[5] = mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[6] = mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[7] = mkv(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[8] = mkv(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[9] = mkv(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Reset state.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_sum", {16'b0, sum}, 32'd0);
    chk("reset_flags", {30'b0, cout, ovf}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors, one at a time, with latency measurement.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(S));
      if (out_valid) begin
        chk($sformatf("vec%0d_sum", i), {16'b0, sum}, {16'b0, vecs[i].exp.sum});
        chk($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].exp.cout});
        chk($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp.ovf});
      end
      tick();
    end

    // Streaming: 8 back-to-back transactions.
    ir_low = 0;
    pat = '0;
    exp_pat = '0;
    for (int i = 0; i < 16; i++) begin
      exp_pat[i] = (i >= int'(S) - 1) && (i < int'(S) - 1 + 8);
      in_valid = (i < 8);
      rand_ops();
      if (!in_ready) ir_low++;
      tick();
      pat[i] = out_valid;
    end
    chk("stream_valid_pattern", {16'b0, pat}, {16'b0, exp_pat});
    chk("stream_in_ready_low", 32'(ir_low), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: pipeline fills to exactly S then refuses more.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_ops();
      if (in_ready) n_acc++;
      tick();
    end
    chk("bp_accepted", 32'(n_acc), 32'(S));
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_released_count", 32'(n_out), 32'(S));
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three transactions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h1234 + 16'(i); b = 16'h1111; cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rst_pre_out_valid", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_async_sum", {16'b0, sum}, 32'd0);
    chk("rst_async_flags", {30'b0, cout, ovf}, 32'd0);
    chk("rst_async_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    stall_seen = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
